// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a latched WIDTH-bit pattern MSB-first, reps+1 times, with GAP idle cycles between frames.
// Optional even-parity bit appended to each frame when SEQ_GEN_PARITY_EN is defined.
module seq_pattern_gen #(
   parameter int WIDTH = 4,
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] pattern,
   input  logic [3:0]       reps,
   input  logic             abort,
   output logic             d_out,
   output logic             busy,
   output logic             done,
   output logic [3:0]       states
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_SHIFT = 4'b0010,
      S_GAP   = 4'b0100,
      S_DONE  = 4'b1000
   } state_t;

   localparam int BW = $clog2(WIDTH + 1);
`ifdef SEQ_GEN_PARITY_EN
   localparam int FLEN = WIDTH + 1;
   localparam logic [BW-1:0] PAR_IDX = BW'(WIDTH - 1);
`else
   localparam int FLEN = WIDTH;
`endif
   localparam logic [BW-1:0] BIT_LAST = BW'(FLEN - 1);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

   state_t           state;
   logic [WIDTH-1:0] pat_q;
   logic [WIDTH-1:0] sh;
   logic [BW-1:0]    bit_cnt;
   logic [3:0]       frame_cnt;
   logic [GW-1:0]    gap_cnt;

`ifdef SEQ_GEN_PARITY_EN
   logic par;
   assign par = ^pat_q;
`endif

   assign states     = state;
   assign load_ready = (state == S_IDLE);

   // bit_cnt holds the index of the bit currently on d_out; sh is pre-shifted one bit ahead.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_IDLE;
         d_out     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         bit_cnt   <= '0;
         frame_cnt <= '0;
         gap_cnt   <= '0;
         pat_q     <= '0;
         sh        <= '0;
      end else if (abort) begin
         state     <= S_IDLE;
         d_out     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         bit_cnt   <= '0;
         frame_cnt <= '0;
         gap_cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (load_valid) begin
                  pat_q     <= pattern;
                  sh        <= pattern << 1;
                  d_out     <= pattern[WIDTH-1];
                  bit_cnt   <= '0;
                  frame_cnt <= reps;
                  busy      <= 1'b1;
                  state     <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (bit_cnt != BIT_LAST) begin
                  bit_cnt <= bit_cnt + 1'b1;
                  sh      <= sh << 1;
`ifdef SEQ_GEN_PARITY_EN
                  d_out   <= (bit_cnt == PAR_IDX) ? par : sh[WIDTH-1];
`else
                  d_out   <= sh[WIDTH-1];
`endif
               end else begin
                  bit_cnt <= '0;
                  if (frame_cnt != 4'd0) begin
                     frame_cnt <= frame_cnt - 4'd1;
                     if (GAP > 0) begin
                        state   <= S_GAP;
                        d_out   <= 1'b0;
                        gap_cnt <= '0;
                     end else begin
                        d_out <= pat_q[WIDTH-1];
                        sh    <= pat_q << 1;
                     end
                  end else begin
                     state <= S_DONE;
                     d_out <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state   <= S_SHIFT;
                  d_out   <= pat_q[WIDTH-1];
                  sh      <= pat_q << 1;
                  bit_cnt <= '0;
                  gap_cnt <= '0;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               d_out <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: two instances (GAP=0 and GAP=2); expected serial streams are queued at issue time.
module tb_seq_pattern_gen;

`ifdef SEQ_GEN_PARITY_EN
   localparam int FLEN = 5;
`else
   localparam int FLEN = 4;
`endif
   localparam int HS_N = FLEN + 3;

   logic       clk = 1'b0;
   logic       reset, abort, lv0, lv2;
   logic [3:0] pattern, reps;
   logic       lr0, d0, b0, dn0;
   logic       lr2, d2, b2, dn2;
   logic [3:0] st0, st2;

   int n_tests = 0;
   int n_fail  = 0;
   logic [2:0] q0[$];
   logic [2:0] q2[$];

   always #5 clk = ~clk;

   seq_pattern_gen #(.WIDTH(4), .GAP(0)) u0 (
      .clk(clk), .reset(reset), .load_valid(lv0), .load_ready(lr0),
      .pattern(pattern), .reps(reps), .abort(abort),
      .d_out(d0), .busy(b0), .done(dn0), .states(st0)
   );

   seq_pattern_gen #(.WIDTH(4), .GAP(2)) u2 (
      .clk(clk), .reset(reset), .load_valid(lv2), .load_ready(lr2),
      .pattern(pattern), .reps(reps), .abort(abort),
      .d_out(d2), .busy(b2), .done(dn2), .states(st2)
   );

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Entries are {d_out, busy, done}, popped whenever the instance is busy or pulsing done.
   always @(negedge clk) begin : mon0
      logic [2:0] e;
      if (b0 || dn0) begin
         if (q0.size() == 0) check("u0_unexpected_output", int'({d0, b0, dn0}), 0);
         else begin
            e = q0.pop_front();
            check("u0_stream", int'({d0, b0, dn0}), int'(e));
         end
      end
   end

   always @(negedge clk) begin : mon2
      logic [2:0] e;
      if (b2 || dn2) begin
         if (q2.size() == 0) check("u2_unexpected_output", int'({d2, b2, dn2}), 0);
         else begin
            e = q2.pop_front();
            check("u2_stream", int'({d2, b2, dn2}), int'(e));
         end
      end
   end

   task automatic push(input int sel, input logic [31:0] bits, input int n, input bit with_done);
      logic [2:0] ent;
      for (int i = n - 1; i >= 0; i--) begin
         ent = {bits[i], 1'b1, 1'b0};
         if (sel == 0) q0.push_back(ent); else q2.push_back(ent);
      end
      if (with_done) begin
         if (sel == 0) q0.push_back(3'b001); else q2.push_back(3'b001);
      end
   endtask

   task automatic accept(input int sel, input logic [3:0] pat, input logic [3:0] r);
      pattern = pat;
      reps    = r;
      if (sel == 0) lv0 = 1'b1; else lv2 = 1'b1;
      @(posedge clk); #1;
      lv0 = 1'b0;
      lv2 = 1'b0;
   endtask

   task automatic wait_done(input int sel, input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = (sel == 0) ? dn0 : dn2;
      end
      check({name, "_done_seen"}, int'(seen), 1);
      @(negedge clk);
      check({name, "_ready_after_done"}, int'((sel == 0) ? lr0 : lr2), 1);
      check({name, "_queue_drained"}, (sel == 0) ? q0.size() : q2.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] tbl [8];
      tbl = '{4'b1101, 4'b0011, 4'b1000, 4'b1110, 4'b0101, 4'b1111, 4'b0110, 4'b1010};

      reset = 1'b0; abort = 1'b0; lv0 = 1'b1; lv2 = 1'b1;
      pattern = 4'hF; reps = 4'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_states_u0", int'(st0), 1);
      check("reset_states_u2", int'(st2), 1);
      check("reset_dout_u0", int'(d0), 0);
      check("reset_ready_u0", int'(lr0), 1);
      check("reset_busy_u0", int'(b0), 0);
      check("reset_done_u2", int'(dn2), 0);
      lv0 = 1'b0; lv2 = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;

      // Abort in IDLE outranks load_valid
      abort = 1'b1; lv0 = 1'b1; pattern = 4'b1010;
      @(posedge clk); #1;
      abort = 1'b0; lv0 = 1'b0;
      check("idle_abort_states", int'(st0), 1);
      check("idle_abort_busy", int'(b0), 0);

      // Single frame 1011
`ifdef SEQ_GEN_PARITY_EN
      push(0, 32'b10111, 5, 1'b1);
`else
      push(0, 32'b1011, 4, 1'b1);
`endif
      accept(0, 4'b1011, 4'd0);
      wait_done(0, "single");

      // Three frames of 1100 with GAP=2
`ifdef SEQ_GEN_PARITY_EN
      push(1, 32'b1100000110000011000, 19, 1'b1);
`else
      push(1, 32'b1100001100001100, 16, 1'b1);
`endif
      accept(1, 4'b1100, 4'd2);
      wait_done(1, "gap");

      // Two back-to-back frames of 1001
`ifdef SEQ_GEN_PARITY_EN
      push(0, 32'b1001010010, 10, 1'b1);
`else
      push(0, 32'b10011001, 8, 1'b1);
`endif
      accept(0, 4'b1001, 4'd1);
      wait_done(0, "b2b");

      // Abort at the edge that would drive the third bit of 1111
      push(0, 32'b11, 2, 1'b0);
      accept(0, 4'b1111, 4'd0);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_states", int'(st0), 1);
      check("abort_dout", int'(d0), 0);
      check("abort_busy", int'(b0), 0);
      check("abort_done", int'(dn0), 0);
      repeat (3) @(negedge clk);
      check("abort_queue_drained", q0.size(), 0);
      @(posedge clk); #1;

      // load_valid held high while pattern/reps keep changing
`ifdef SEQ_GEN_PARITY_EN
      push(0, 32'b11011, 5, 1'b1);
      push(0, 32'b10100, 5, 1'b1);
`else
      push(0, 32'b1101, 4, 1'b1);
      push(0, 32'b0110, 4, 1'b1);
`endif
      lv0 = 1'b1;
      for (int i = 0; i < HS_N; i++) begin
         pattern = tbl[i];
         reps    = (i == 0 || i == HS_N - 1) ? 4'd0 : 4'd15;
         @(posedge clk); #1;
      end
      lv0 = 1'b0;
      wait_done(0, "handshake");
      repeat (3) @(negedge clk);
      check("final_u0_idle", int'(st0), 1);
      check("final_u2_idle", int'(st2), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

- Serial pattern transmitter: the stimulus-side counterpart of the Mealy sequence detector.
- Accepts a parallel pattern and a repeat count over a valid/ready handshake, then drives it MSB-first on a single-bit `d_out`, one bit per clock.
- Inserts a programmable idle gap between repeated frames and pulses `done` at the end.
- Feeds the detector's `d_in` in system-level benches, and serves as a reusable serial source in the design.

## Interface

Parameters:
- `WIDTH`, default 4: pattern length in bits (≥2).
- `GAP`, default 0: idle cycles between consecutive frames (0 = back-to-back).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `load_valid`  in  1  request to start a transfer.
- `load_ready`  out  1  high only in IDLE; transfer accepted when `load_valid && load_ready` at a rising edge.
- `pattern`  in  WIDTH  bits to send, captured at acceptance.
- `reps`  in  4  number of frames minus one (0 = 1 frame, 15 = 16 frames), captured at acceptance.
- `abort`  in  1  synchronous cancel.
- `d_out`  out  1  registered serial data.
- `busy`  out  1  high in SHIFT or GAP.
- `done`  out  1  one-cycle pulse in DONE.
- `states`  out  4  one-hot state: IDLE=0001, SHIFT=0010, GAP=0100, DONE=1000.

## Operation

- Reset (`reset`=0 at an edge) takes priority over all inputs and forces:
  - state IDLE (`states`=0001), `d_out`=0, `busy`=0, `done`=0, `load_ready`=1;
  - bit and frame counters cleared.
- IDLE:
  - On acceptance, latch `pattern` into the shift register and `reps` into the frame counter, then go to SHIFT.
  - `pattern` and `reps` changes outside acceptance are ignored.
- SHIFT:
  - Outputs the frame, MSB first.
  - Frame length L = WIDTH bits, or WIDTH+1 with parity enabled (see Configuration).
  - After the last bit of the frame:
    - if frames remain and GAP>0, go to GAP;
    - if frames remain and GAP=0, reload the latched pattern and stay in SHIFT;
    - otherwise go to DONE.
- GAP:
  - `d_out`=0 for exactly GAP cycles, then SHIFT with the pattern reloaded.
- DONE:
  - One cycle with `done`=1, `d_out`=0, `busy`=0; then IDLE.
- Abort:
  - `abort`=1 in SHIFT, GAP or DONE returns the block to IDLE at that edge.
  - At that edge: `d_out`=0, no `done` pulse, counters cleared.
  - In IDLE, `abort` has priority over `load_valid`, so no acceptance occurs.
- Counters:
  - Bit counter is $clog2(WIDTH+1) wide and wraps per frame.
  - Frame counter is 4 bits and decrements at the end of each frame; DONE is entered when the counter is 0 at end of frame.

## Timing

- Acceptance at edge k:
  - the first bit (`pattern[WIDTH-1]`) is valid on `d_out` from edge k to edge k+1;
  - `load_ready` is 0 from edge k.
- Bit i of a frame is driven for one full cycle; there are no stall inputs once started.
- Total length for F = reps+1 frames: F·L + (F−1)·GAP cycles of SHIFT/GAP, then 1 cycle DONE.
- `load_ready` returns to 1 on the edge after DONE. The earliest next acceptance is therefore one cycle after `done`.
- All outputs are registered; there are no combinational input-to-output paths except `load_ready`, which is decoded from the state register.
- A reset or abort asserted mid-frame truncates output immediately: the last driven bit is the one before the abort edge.

## Configuration

- `SEQ_GEN_PARITY_EN` defined:
  - each frame gets one extra bit after the LSB, L = WIDTH+1;
  - the extra bit is even parity (XOR of the latched pattern);
  - in GAP=0 back-to-back mode, the parity bit is followed directly by the next frame's MSB.
- Not defined: L = WIDTH; no parity logic is instantiated.

## Test plan

- Reset: hold `reset`=0 two cycles with `load_valid`=1 → `states`=0001, `d_out`=0, `load_ready`=1, no acceptance.
- Single frame (WIDTH=4, GAP=0, pattern=1011, reps=0) → `d_out` 1,0,1,1 on four consecutive cycles; `done` pulses on the 5th; `load_ready` is 1 on the 6th. Feeding the detector this stream must give its 1011 hit.
- Repeat with gap (GAP=2, pattern=1100, reps=2) → `d_out` 1100 00 1100 00 1100, then `done`; `busy` is high for 16 cycles.
- Back-to-back (GAP=0, pattern=1001, reps=1) → 10011001 with no idle bit, then `done`. With `SEQ_GEN_PARITY_EN`: 1001 0 1001 0.
- Abort: assert `abort` on the 3rd bit of pattern=1111 → `d_out`=1,1 then 0; `states`=0001 at the next edge; `done` never pulses.
- Handshake: `load_valid` held high continuously with pattern changing → exactly one acceptance per transfer, captured at acceptance; no acceptance while `busy` or in DONE.
